// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect flushes, data-memory wait freeze.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs2_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_redirect_i,
  input  logic        mem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_write_o,
  output logic        idex_flush_o,
  output logic        exmem_write_o,
  output logic        memwb_flush_o,
  output logic        pc_redirect_o,
  output logic        mem_err_o,
  output logic [1:0]  state_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_wait_cnt, w_cnt_nxt;
  logic               r_mem_err, w_err_nxt;

  logic w_lu, w_miss;
  logic w_run_pcw, w_run_ifw, w_run_iff, w_run_idw, w_run_idf, w_run_exw, w_run_red;
  logic w_pcw, w_ifw, w_iff, w_idw, w_idf, w_exw, w_mwf, w_red;

  assign w_lu   = ex_memread_i && (ex_rd_i != 5'd0) &&
                  ((ex_rd_i == id_rs1_i) || (id_use_rs2_i && (ex_rd_i == id_rs2_i)));
  assign w_miss = mem_req_i && !dmem_ready_i;

  // Unfrozen pipeline controls: redirect squashes ID, so it outranks the load-use bubble.
  always_comb begin
    w_run_pcw = 1'b1;
    w_run_ifw = 1'b1;
    w_run_iff = 1'b0;
    w_run_idw = 1'b1;
    w_run_idf = 1'b0;
    w_run_exw = 1'b1;
    w_run_red = 1'b0;
    if (ex_redirect_i) begin
      w_run_red = 1'b1;
      w_run_iff = 1'b1;
      w_run_idf = 1'b1;
    end else if (w_lu) begin
      w_run_pcw = 1'b0;
      w_run_ifw = 1'b0;
      w_run_idf = 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_wait_cnt;
    w_err_nxt = r_mem_err;
    w_pcw     = 1'b0;
    w_ifw     = 1'b0;
    w_iff     = 1'b0;
    w_idw     = 1'b0;
    w_idf     = 1'b0;
    w_exw     = 1'b0;
    w_mwf     = 1'b1;
    w_red     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_miss) begin
          w_next    = ST_WAIT;
          w_cnt_nxt = CNT_W'(1);
        end else begin
          w_pcw = w_run_pcw;
          w_ifw = w_run_ifw;
          w_iff = w_run_iff;
          w_idw = w_run_idw;
          w_idf = w_run_idf;
          w_exw = w_run_exw;
          w_mwf = 1'b0;
          w_red = w_run_red;
        end
      end
      ST_WAIT: begin
        if (dmem_ready_i) begin
          w_next    = ST_RUN;
          w_cnt_nxt = '0;
          w_pcw     = w_run_pcw;
          w_ifw     = w_run_ifw;
          w_iff     = w_run_iff;
          w_idw     = w_run_idw;
          w_idf     = w_run_idf;
          w_exw     = w_run_exw;
          w_mwf     = 1'b0;
          w_red     = w_run_red;
        end else if (r_wait_cnt >= CNT_W'(MEM_TIMEOUT)) begin
          w_next    = ST_ERR;
          w_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      ST_ERR: begin
        w_next = ST_ERR;
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_cnt_nxt;
      r_mem_err  <= w_err_nxt;
    end
  end

  // Reset forces every enable/flush low even though the FSM already sits in RUN.
  assign pc_write_o    = rst_i & w_pcw;
  assign ifid_write_o  = rst_i & w_ifw;
  assign ifid_flush_o  = rst_i & w_iff;
  assign idex_write_o  = rst_i & w_idw;
  assign idex_flush_o  = rst_i & w_idf;
  assign exmem_write_o = rst_i & w_exw;
  assign memwb_flush_o = rst_i & w_mwf;
  assign pc_redirect_o = rst_i & w_red;
  assign mem_err_o     = r_mem_err;
  assign state_o       = r_state;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pcw && (r_state != ST_ERR) && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_red && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); counter checks only when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       id_use_rs2_i, ex_memread_i, ex_redirect_i, mem_req_i, dmem_ready_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_flush_o;
  logic       exmem_write_o, memwb_flush_o, pc_redirect_o, mem_err_o;
  logic [1:0] state_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush, pc_redirect}
  localparam logic [7:0] C_OFF = 8'b0000_0000;
  localparam logic [7:0] C_RUN = 8'b1101_0100;
  localparam logic [7:0] C_LU  = 8'b0001_1100;
  localparam logic [7:0] C_RED = 8'b1111_1101;
  localparam logic [7:0] C_FRZ = 8'b0000_0010;

  logic [7:0] ctrl;
  assign ctrl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                 idex_flush_o, exmem_write_o, memwb_flush_o, pc_redirect_o};

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .ex_redirect_i(ex_redirect_i),
    .mem_req_i(mem_req_i), .dmem_ready_i(dmem_ready_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_write_o(idex_write_o), .idex_flush_o(idex_flush_o), .exmem_write_o(exmem_write_o),
    .memwb_flush_o(memwb_flush_o), .pc_redirect_o(pc_redirect_o),
    .mem_err_o(mem_err_o), .state_o(state_o)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_use_rs2_i = 1'b0;
    ex_memread_i = 1'b0; ex_rd_i = 5'd0; ex_redirect_i = 1'b0;
    mem_req_i = 1'b0; dmem_ready_i = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic use2);
    ex_memread_i = 1'b1; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2; id_use_rs2_i = use2;
  endtask

  initial begin
    // Reset with every hazard input active
    rst_i = 1'b0;
    set_lu(5'd5, 5'd5, 5'd0, 1'b0);
    ex_redirect_i = 1'b1; mem_req_i = 1'b1; dmem_ready_i = 1'b0;
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'(C_OFF));
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_err", 32'(mem_err_o), 32'd0);
    tick(); tick();
    chk("rst_hold_ctrl", 32'(ctrl), 32'(C_OFF));
    idle();
    rst_i = 1'b1;
    #1;
    chk("run_default", 32'(ctrl), 32'(C_RUN));

    // Load-use on rs1, then bubble clears
    set_lu(5'd5, 5'd5, 5'd0, 1'b0);
    #1 chk("lu_rs1", 32'(ctrl), 32'(C_LU));
    tick();
    ex_memread_i = 1'b0;
    #1 chk("lu_rs1_after", 32'(ctrl), 32'(C_RUN));
    tick();

    // x0 and rs2 gating
    set_lu(5'd0, 5'd0, 5'd0, 1'b1);
    #1 chk("lu_x0", 32'(ctrl), 32'(C_RUN));
    tick();
    set_lu(5'd7, 5'd3, 5'd7, 1'b0);
    #1 chk("lu_rs2_unused", 32'(ctrl), 32'(C_RUN));
    tick();
    set_lu(5'd7, 5'd3, 5'd7, 1'b1);
    #1 chk("lu_rs2_used", 32'(ctrl), 32'(C_LU));
    tick();

    // Redirect together with load-use: redirect wins
    set_lu(5'd9, 5'd9, 5'd0, 1'b0);
    ex_redirect_i = 1'b1;
    #1 chk("redirect_lu", 32'(ctrl), 32'(C_RED));
    tick();
    idle();
    #1;

    // Memory wait three cycles with a pending redirect, then completion
    mem_req_i = 1'b1; dmem_ready_i = 1'b0; ex_redirect_i = 1'b1;
    #1 chk("mw_c1_ctrl", 32'(ctrl), 32'(C_FRZ));
    chk("mw_c1_state", 32'(state_o), 32'd0);
    tick();
    chk("mw_c2_ctrl", 32'(ctrl), 32'(C_FRZ));
    chk("mw_c2_state", 32'(state_o), 32'd1);
    tick();
    chk("mw_c3_ctrl", 32'(ctrl), 32'(C_FRZ));
    chk("mw_c3_state", 32'(state_o), 32'd1);
    tick();
    dmem_ready_i = 1'b1;
    #1 chk("mw_c4_ctrl", 32'(ctrl), 32'(C_RED));
    chk("mw_c4_state", 32'(state_o), 32'd1);
    tick();
    idle();
    #1 chk("mw_done_state", 32'(state_o), 32'd0);
    chk("mw_done_ctrl", 32'(ctrl), 32'(C_RUN));
    tick();

    // Reset in the middle of a wait
    mem_req_i = 1'b1; dmem_ready_i = 1'b0;
    tick();
    chk("abort_pre_state", 32'(state_o), 32'd1);
    rst_i = 1'b0;
    #1 chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_ctrl", 32'(ctrl), 32'(C_OFF));
    tick();
    idle();
    rst_i = 1'b1;
    #1 chk("abort_release", 32'(ctrl), 32'(C_RUN));
    tick();

    // Timeout: five stall cycles reach ERROR
    mem_req_i = 1'b1; dmem_ready_i = 1'b0;
    #1 chk("to_c1_err", 32'(mem_err_o), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("to_wait%0d_state", i), 32'(state_o), 32'd1);
      chk($sformatf("to_wait%0d_err", i), 32'(mem_err_o), 32'd0);
    end
    tick();
    chk("to_err_state", 32'(state_o), 32'd2);
    chk("to_err_flag", 32'(mem_err_o), 32'd1);
    chk("to_err_ctrl", 32'(ctrl), 32'(C_FRZ));
    idle();
    ex_redirect_i = 1'b1;
    tick(); tick();
    chk("to_sticky_state", 32'(state_o), 32'd2);
    chk("to_sticky_flag", 32'(mem_err_o), 32'd1);
    chk("to_sticky_ctrl", 32'(ctrl), 32'(C_FRZ));
    rst_i = 1'b0;
    #1 chk("to_clr_state", 32'(state_o), 32'd0);
    chk("to_clr_flag", 32'(mem_err_o), 32'd0);
    tick();
    idle();
    rst_i = 1'b1;
    #1;

`ifdef PIPE_HAZARD_PERF_EN
    // 1 load-use + 3 frozen cycles + 2 redirects
    chk("perf_rst_stall", stall_cnt_o, 32'd0);
    chk("perf_rst_flush", flush_cnt_o, 32'd0);
    set_lu(5'd5, 5'd5, 5'd0, 1'b0);
    tick();
    idle();
    mem_req_i = 1'b1; dmem_ready_i = 1'b0;
    tick(); tick(); tick();
    dmem_ready_i = 1'b1;
    tick();
    idle();
    ex_redirect_i = 1'b1;
    tick(); tick();
    idle();
    tick();
    chk("perf_stall", stall_cnt_o, 32'd4);
    chk("perf_flush", flush_cnt_o, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
